// File: rtl/sargantana_icache_refill_buf.sv
// rtl/sargantana_icache_refill_buf.sv - icache line refill buffer: one IFILL request, beat collection, line hand-off
// Optional feature macro: ICACHE_REFILL_TIMEOUT_EN (abort a stalled FILL/DRAIN after TMO_CYC beat-less cycles).

module sargantana_icache_refill_buf #(
  parameter int ADDR_W  = 40,
  parameter int LINE_W  = 512,
  parameter int BEAT_W  = 128,
  parameter int TMO_CYC = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              miss_i,
  input  logic [ADDR_W-1:0] miss_paddr_i,
  input  logic              miss_nc_i,
  input  logic              kill_i,
  output logic              ifill_req_valid_o,
  input  logic              ifill_req_ready_i,
  output logic [ADDR_W-1:0] ifill_req_addr_o,
  output logic              ifill_req_nc_o,
  input  logic              mem_beat_valid_i,
  input  logic [BEAT_W-1:0] mem_beat_data_i,
  input  logic              mem_beat_last_i,
  input  logic              mem_beat_err_i,
  output logic              ifill_sent_ack_o,
  output logic              ifill_resp_valid_o,
  output logic              ifill_resp_ack_o,
  output logic [LINE_W-1:0] line_data_o,
  output logic [ADDR_W-1:0] line_addr_o,
  output logic              line_nc_o,
  output logic              line_err_o,
  output logic              busy_o
);

  localparam int N_BEATS = LINE_W / BEAT_W;
  localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int OFF_W   = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_FILL  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              nc_q;

  // Control strobes from the next-state logic into the datapath
  logic latch_miss;
  logic beat_write;
  logic cnt_inc;
  logic cnt_clr;
  logic err_set;

  // Offset bits inside the line are dropped on purpose: requests are line-aligned
  logic unused_paddr_lo;
  assign unused_paddr_lo = ^miss_paddr_i[OFF_W-1:0];

  assign ifill_req_addr_o = addr_q;
  assign ifill_req_nc_o   = nc_q;
  assign line_addr_o      = addr_q;
  assign line_nc_o        = nc_q;

`ifdef ICACHE_REFILL_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TMO_CYC + 1) > 10) ? $clog2(TMO_CYC + 1) : 10;

  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit;

  assign tmo_hit = (tmo_q == TMO_W'(TMO_CYC));

  // Beat-less cycle counter; restarts on every beat and on every state change
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else if ((state_q == S_FILL || state_q == S_DRAIN) &&
                 !mem_beat_valid_i && (state_d == state_q)) begin
      tmo_q <= tmo_q + 1'b1;
    end else begin
      tmo_q <= '0;
    end
  end
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TMO_CYC);
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode, handshake outputs and datapath strobes
  always_comb begin
    state_d            = state_q;
    ifill_req_valid_o  = 1'b0;
    ifill_sent_ack_o   = 1'b0;
    ifill_resp_valid_o = 1'b0;
    ifill_resp_ack_o   = 1'b0;
    busy_o             = (state_q != S_IDLE);
    latch_miss         = 1'b0;
    beat_write         = 1'b0;
    cnt_inc            = 1'b0;
    cnt_clr            = 1'b0;
    err_set            = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (miss_i) begin
          latch_miss = 1'b1;
          cnt_clr    = 1'b1;
          state_d    = S_REQ;
        end
      end

      S_REQ: begin
        ifill_req_valid_o = 1'b1;
        if (ifill_req_ready_i) begin
          // Once memory has taken the request its beats will come back, so a
          // same-cycle kill has to drain them rather than drop to IDLE.
          ifill_sent_ack_o = 1'b1;
          state_d          = kill_i ? S_DRAIN : S_FILL;
        end else if (kill_i) begin
          state_d = S_IDLE;
        end
      end

      S_FILL: begin
        if (kill_i) begin
          if (mem_beat_valid_i) begin
            if (mem_beat_last_i || cnt_q == LAST_CNT) begin
              cnt_clr = 1'b1;
              state_d = S_IDLE;
            end else begin
              cnt_inc = 1'b1;
              state_d = S_DRAIN;
            end
          end else begin
            state_d = S_DRAIN;
          end
        end else if (mem_beat_valid_i) begin
          beat_write = 1'b1;
          if (mem_beat_err_i) begin
            err_set = 1'b1;
          end
          if (cnt_q == LAST_CNT) begin
            cnt_clr = 1'b1;
            state_d = S_DONE;
            if (!mem_beat_last_i) begin
              err_set = 1'b1;
            end
          end else if (mem_beat_last_i) begin
            cnt_clr = 1'b1;
            err_set = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
`ifdef ICACHE_REFILL_TIMEOUT_EN
        else if (tmo_hit) begin
          cnt_clr = 1'b1;
          err_set = 1'b1;
          state_d = S_DONE;
        end
`endif
      end

      S_DONE: begin
        ifill_resp_valid_o = 1'b1;
        ifill_resp_ack_o   = 1'b1;
        state_d            = S_IDLE;
      end

      S_DRAIN: begin
        if (mem_beat_valid_i) begin
          if (mem_beat_last_i || cnt_q == LAST_CNT) begin
            cnt_clr = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
`ifdef ICACHE_REFILL_TIMEOUT_EN
        else if (tmo_hit) begin
          cnt_clr = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line address/attributes, beat counter, error flag and line assembly
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      nc_q        <= 1'b0;
      cnt_q       <= '0;
      line_err_o  <= 1'b0;
      line_data_o <= '0;
    end else begin
      if (latch_miss) begin
        addr_q     <= {miss_paddr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        nc_q       <= miss_nc_i;
        line_err_o <= 1'b0;
      end

      if (err_set) begin
        line_err_o <= 1'b1;
      end

      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end

      for (int b = 0; b < N_BEATS; b++) begin
        if (beat_write && cnt_q == CNT_W'(b)) begin
          line_data_o[b*BEAT_W +: BEAT_W] <= mem_beat_data_i;
        end
      end
    end
  end

endmodule
